// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/line types and line-address helpers
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  // Byte offset within a 16-byte line; the remaining address bits form the tag.
  localparam int LC3B_OFFSET_W = 4;

  typedef logic [15-LC3B_OFFSET_W:0] lc3b_line_tag;

  // Line-aligned byte address for a tag.
  function automatic lc3b_word line_addr(input lc3b_line_tag tag);
    return {tag, {LC3B_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/wbuf_entry_array.sv
// rtl/wbuf_entry_array.sv - circular FIFO of buffered lines with tag lookup
module wbuf_entry_array
  import lc3b_types::*;
#(
  parameter  int DEPTH = 2,
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  lc3b_line_tag lookup_tag_i,
  output logic         hit_o,
  output logic [IW-1:0] hit_idx_o,
  output lc3b_line     hit_line_o,
  input  logic         enq_i,
  input  lc3b_line_tag enq_tag_i,
  input  lc3b_line     enq_line_i,
  input  logic         ovw_i,
  input  logic [IW-1:0] ovw_idx_i,
  input  lc3b_line     ovw_line_i,
  input  logic         pop_i,
  output lc3b_line_tag head_tag_o,
  output lc3b_line     head_line_o,
  output logic [CW-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [DEPTH-1:0] valid_q;
  lc3b_line_tag     tag_q  [DEPTH];
  lc3b_line         line_q [DEPTH];
  logic [IW-1:0]    head_q;
  logic [IW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
    if (p == IW'(DEPTH - 1)) return '0;
    return p + IW'(1);
  endfunction

  // Valid bits and FIFO pointers; the FSM never pops and enqueues together,
  // but both are handled so the array stays self-consistent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop_i) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= wrap_inc(head_q);
      end
      if (enq_i) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= wrap_inc(tail_q);
      end
      case ({enq_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag and line payload; qualified by valid_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq_i) begin
      tag_q[tail_q]  <= enq_tag_i;
      line_q[tail_q] <= enq_line_i;
    end
    if (ovw_i) begin
      line_q[ovw_idx_i] <= ovw_line_i;
    end
  end

  // Associative lookup; coalescing keeps at most one valid entry per tag.
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == lookup_tag_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = IW'(i);
      end
    end
  end

  assign hit_line_o  = line_q[hit_idx_o];
  assign head_tag_o  = tag_q[head_q];
  assign head_line_o = line_q[head_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);

endmodule

// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - write-back line buffer between cache and pmem
module writeback_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     cache_read,
  input  logic     cache_write,
  input  lc3b_word cache_address,
  input  lc3b_line cache_wdata,
  output lc3b_line cache_rdata,
  output logic     cache_resp,
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp,
  output logic     wb_empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PMEM_READ  = 2'd1,
    PMEM_WRITE = 2'd2,
    RESPOND    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  lc3b_line      rdata_q, rdata_d;

  lc3b_line_tag  req_tag;
  logic          hit;
  logic [IW-1:0] hit_idx;
  lc3b_line      hit_line;
  logic          enq, ovw, pop;
  lc3b_line_tag  head_tag;
  lc3b_line      head_line;
  logic [CW-1:0] count;
  logic          full, empty;

  logic          unused_offset;

  assign req_tag       = cache_address[15:LC3B_OFFSET_W];
  assign unused_offset = ^cache_address[LC3B_OFFSET_W-1:0];

  wbuf_entry_array #(.DEPTH(DEPTH)) u_entries (
    .clk          (clk),
    .reset        (reset),
    .lookup_tag_i (req_tag),
    .hit_o        (hit),
    .hit_idx_o    (hit_idx),
    .hit_line_o   (hit_line),
    .enq_i        (enq),
    .enq_tag_i    (req_tag),
    .enq_line_i   (cache_wdata),
    .ovw_i        (ovw),
    .ovw_idx_i    (hit_idx),
    .ovw_line_i   (cache_wdata),
    .pop_i        (pop),
    .head_tag_o   (head_tag),
    .head_line_o  (head_line),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  // State and read-data registers; reset abandons any pmem transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state, buffer controls and Moore outputs.
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    enq          = 1'b0;
    ovw          = 1'b0;
    pop          = 1'b0;
    cache_resp   = 1'b0;
    cache_rdata  = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        // A read wins over a write if both are (illegally) raised.
        if (cache_read) begin
          if (hit) begin
            rdata_d = hit_line;
            state_d = RESPOND;
          end else begin
            state_d = PMEM_READ;
          end
        end else if (cache_write) begin
          if (hit) begin
            ovw     = 1'b1;
            state_d = RESPOND;
          end else if (!full) begin
            enq     = 1'b1;
            state_d = RESPOND;
          end else begin
            // Buffer full: drain the head; the cache keeps holding its write.
            state_d = PMEM_WRITE;
          end
        end else if (!empty) begin
          state_d = PMEM_WRITE;
        end
      end
      PMEM_READ: begin
        pmem_read    = 1'b1;
        pmem_address = line_addr(req_tag);
        if (pmem_resp) begin
          rdata_d = pmem_rdata;
          state_d = RESPOND;
        end
      end
      PMEM_WRITE: begin
        pmem_write   = 1'b1;
        pmem_address = line_addr(head_tag);
        pmem_wdata   = head_line;
        if (pmem_resp) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      RESPOND: begin
        cache_resp  = 1'b1;
        cache_rdata = rdata_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_empty = (count == '0);

endmodule

// File: tb/tb_writeback_buffer.sv
// tb/tb_writeback_buffer.sv - directed self-checking bench for writeback_buffer
module tb_writeback_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         cache_read, cache_write;
  logic [15:0]  cache_address;
  logic [127:0] cache_wdata, cache_rdata;
  logic         cache_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic         wb_empty;

  writeback_buffer #(.DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .cache_read    (cache_read),
    .cache_write   (cache_write),
    .cache_address (cache_address),
    .cache_wdata   (cache_wdata),
    .cache_rdata   (cache_rdata),
    .cache_resp    (cache_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .wb_empty      (wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [15:0]  a;
    logic [127:0] d;
  } txn_t;

  txn_t log_q[$];
  int   total = 0;
  int   bad = 0;
  int   pmem_lat = 1;
  int   lat_cnt = 0;
  int   pmem_act = 0;

  localparam logic [127:0] LA = {32{4'hA}};
  localparam logic [127:0] LB = {32{4'hB}};
  localparam logic [127:0] LC = {32{4'hC}};
  localparam logic [127:0] LD = {32{4'hD}};
  localparam logic [127:0] LE = {32{4'hE}};
  localparam logic [127:0] LF = {32{4'hF}};
  localparam logic [127:0] L1 = {16{8'h11}};
  localparam logic [127:0] L2 = {16{8'h22}};
  localparam logic [127:0] L3 = {16{8'h33}};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // pmem model: responds pmem_lat cycles into a request, read data = 8 copies of address
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (!reset && (pmem_read || pmem_write)) begin
        if (lat_cnt >= pmem_lat) begin
          pmem_resp = 1'b1;
          lat_cnt   = 0;
          if (pmem_read) pmem_rdata = {8{pmem_address}};
          log_q.push_back('{wr: pmem_write, a: pmem_address, d: pmem_wdata});
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  always @(negedge clk) if (pmem_read || pmem_write) pmem_act++;

  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a, input logic [127:0] d,
                        output int cyc, output logic [127:0] rdat);
    bit seen;
    @(posedge clk);
    #1;
    cache_read    = rd;
    cache_write   = wr;
    cache_address = a;
    cache_wdata   = d;
    cyc  = 0;
    seen = 0;
    rdat = '0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cache_resp) begin
        seen = 1;
        rdat = cache_rdata;
      end
    end
    chk("resp_seen", seen, 1);
  endtask

  task automatic drop();
    @(posedge clk);
    #1;
    cache_read  = 1'b0;
    cache_write = 1'b0;
  endtask

  task automatic drain_all();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wb_empty && !pmem_write) && n < 400);
    chk("drain_done", wb_empty && !pmem_write, 1);
  endtask

  int           cyc;
  logic [127:0] rd;
  int           base;

  initial begin
    reset = 1'b1;
    cache_read = 1'b0; cache_write = 1'b0; cache_address = '0; cache_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_empty", wb_empty, 1);
    chk("rst_resp", cache_resp, 0);
    chk("rst_pread", pmem_read, 0);
    chk("rst_pwrite", pmem_write, 0);
    chk("rst_paddr", pmem_address, 0);
    chk("rst_pwdata", pmem_wdata, 0);
    chk("rst_rdata", cache_rdata, 0);
    reset = 1'b0;
    base = pmem_act;
    repeat (5) @(negedge clk);
    chk("idle_quiet", pmem_act - base, 0);

    // write then background drain
    pmem_lat = 3;
    log_q.delete();
    do_req(0, 1, 16'h1234, LA, cyc, rd);
    chk("wr_lat", cyc, 2);
    chk("wr_not_empty", wb_empty, 0);
    drop();
    drain_all();
    chk("wr_n", log_q.size(), 1);
    chk("wr_kind", log_q[0].wr, 1);
    chk("wr_addr", log_q[0].a, 16'h1230);
    chk("wr_data", log_q[0].d, LA);

    // read hit served from buffer
    pmem_lat = 1;
    log_q.delete();
    do_req(0, 1, 16'h4000, LB, cyc, rd);
    do_req(1, 0, 16'h4006, '0, cyc, rd);
    chk("hit_lat", cyc, 2);
    chk("hit_data", rd, LB);
    chk("hit_no_pmem", log_q.size(), 0);
    drop();
    drain_all();
    chk("hit_drain_n", log_q.size(), 1);
    chk("hit_drain_addr", log_q[0].a, 16'h4000);

    // coalescing writes to one line
    log_q.delete();
    do_req(0, 1, 16'h5000, LC, cyc, rd);
    do_req(0, 1, 16'h5008, LD, cyc, rd);
    chk("coal_lat", cyc, 2);
    drop();
    drain_all();
    chk("coal_n", log_q.size(), 1);
    chk("coal_addr", log_q[0].a, 16'h5000);
    chk("coal_data", log_q[0].d, LD);

    // full buffer forces a drain before the third write is accepted
    log_q.delete();
    do_req(0, 1, 16'h1000, L1, cyc, rd);
    do_req(0, 1, 16'h2000, L2, cyc, rd);
    chk("full_lat2", cyc, 2);
    do_req(0, 1, 16'h3000, L3, cyc, rd);
    chk("full_lat3", cyc, 5);
    chk("full_n1", log_q.size(), 1);
    chk("full_a0", log_q[0].a, 16'h1000);
    chk("full_d0", log_q[0].d, L1);
    drop();
    drain_all();
    chk("full_n3", log_q.size(), 3);
    chk("full_a1", log_q[1].a, 16'h2000);
    chk("full_d1", log_q[1].d, L2);
    chk("full_a2", log_q[2].a, 16'h3000);
    chk("full_d2", log_q[2].d, L3);

    // read miss bypasses queued write
    log_q.delete();
    do_req(0, 1, 16'h7000, LE, cyc, rd);
    do_req(1, 0, 16'h6000, '0, cyc, rd);
    chk("byp_lat", cyc, 4);
    chk("byp_data", rd, {8{16'h6000}});
    chk("byp_first_kind", log_q[0].wr, 0);
    chk("byp_first_addr", log_q[0].a, 16'h6000);
    drop();
    drain_all();
    chk("byp_n", log_q.size(), 2);
    chk("byp_wr_addr", log_q[1].a, 16'h7000);
    chk("byp_wr_data", log_q[1].d, LE);

    // reset during a drain with two lines buffered
    pmem_lat = 50;
    log_q.delete();
    do_req(0, 1, 16'h1100, LF, cyc, rd);
    do_req(0, 1, 16'h2200, LF, cyc, rd);
    drop();
    repeat (3) @(negedge clk);
    chk("mid_pwrite", pmem_write, 1);
    chk("mid_not_empty", wb_empty, 0);
    #2 reset = 1'b1;
    #1;
    chk("ar_pwrite", pmem_write, 0);
    chk("ar_resp", cache_resp, 0);
    chk("ar_empty", wb_empty, 1);
    chk("ar_paddr", pmem_address, 0);
    #1 reset = 1'b0;
    base = pmem_act;
    repeat (20) @(negedge clk);
    chk("post_rst_quiet", pmem_act - base, 0);
    chk("post_rst_log", log_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Line-granular write-back buffer between the cache's physical-memory port and physical memory.
- Absorbs dirty-line evictions from the cache and acknowledges them in one cycle.
- Drains buffered lines to pmem in the background and serves cache reads that hit a buffered line without touching pmem.
- Cache read misses that do not hit the buffer bypass queued writes, so line fills are not delayed behind evictions.

Parameters:
DEPTH, 2, number of buffered lines (power of two, >=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
cache_read  in  1  line read request from cache, held until cache_resp
cache_write  in  1  line write (eviction) request from cache, held until cache_resp
cache_address  in  16  lc3b_word byte address; bits [3:0] ignored
cache_wdata  in  128  lc3b_line write data
cache_rdata  out  128  lc3b_line read data, valid while cache_resp=1
cache_resp  out  1  one-cycle completion pulse to cache
pmem_read  out  1  read request to physical memory
pmem_write  out  1  write request to physical memory
pmem_address  out  16  line address to pmem, bits [3:0] always 0
pmem_wdata  out  128  head-entry data
pmem_rdata  in  128  physical memory read data
pmem_resp  in  1  physical memory completion
wb_empty  out  1  no valid entries

Behaviour:
- Reset (async, active-high):
  - All entry valid bits cleared; FIFO head, tail and count set to 0; state set to IDLE.
  - cache_resp, pmem_read and pmem_write are 0; cache_rdata, pmem_address and pmem_wdata are 0; wb_empty is 1.
  - A pmem transaction in flight is abandoned.
- Storage:
  - DEPTH entries, each {valid, tag = address[15:4], line}, organised as a circular FIFO with a count from 0 to DEPTH.
  - Head and tail wrap modulo DEPTH.
  - Coalescing guarantees at most one valid entry per tag.
- Moore FSM with four states. Outputs are decoded from the state plus registered data only.
  - IDLE: nothing asserted. Evaluate in priority order:
    1. cache_read with tag match: latch the entry's line into the rdata register, go to RESPOND.
    2. cache_read without match: go to PMEM_READ.
    3. cache_write with tag match: overwrite that entry's line in place (count unchanged), go to RESPOND.
    4. cache_write, no match, count<DEPTH: enqueue at tail, go to RESPOND.
    5. cache_write, no match, count==DEPTH: go to PMEM_WRITE (forced drain). The write is not accepted; the cache keeps holding it.
    6. No request and count>0: go to PMEM_WRITE (background drain).
    7. Otherwise: stay in IDLE.
  - PMEM_READ:
    - pmem_read=1; pmem_address={cache_address[15:4],4'h0}.
    - On pmem_resp: latch pmem_rdata into the rdata register, go to RESPOND.
  - PMEM_WRITE:
    - pmem_write=1; pmem_address={head.tag,4'h0}; pmem_wdata=head.line.
    - On pmem_resp: invalidate head, advance head, decrement count, go to IDLE.
    - A drain in progress is never aborted; cache requests wait.
  - RESPOND:
    - cache_resp=1 for exactly one cycle; cache_rdata = rdata register (the value on a write response is don't-care).
    - Always go to IDLE next.
- Latency:
  - Buffer hit or accepted write: cache_resp two cycles after the request is first seen in IDLE (IDLE→RESPOND).
  - Miss: 1 + pmem latency + 1.
- Request handling: the cache drops its request in the cycle after cache_resp. Any request seen in IDLE is treated as new.
- Simultaneous read and write: not legal from the cache. The buffer treats it as a read (priority 1/2).
- Hazard: a read can never observe stale pmem data. A matching entry is always served by rule 1, because coalescing leaves one entry per tag.
- wb_empty is combinational from count==0.

Decomposition:
- Additions to the lc3b_types package:
  - lc3b_line_tag (logic [11:0]).
  - The constant for the offset width (4).
- The FSM state enum stays local to writeback_buffer.
- One sub-module, wbuf_entry_array:
  - Holds the valid/tag/line registers and the head/tail/count pointers.
  - Provides a combinational tag-match index and hit flag, enqueue/overwrite/pop controls, and head outputs.
- The FSM lives in writeback_buffer.

Test Plan:
- Reset: assert reset while in PMEM_WRITE with count=2 → within the same cycle pmem_write=0, cache_resp=0, wb_empty=1; after release, no pmem activity without requests.
- Write then drain: cache_write 0x1234, data 128'hA…A, pmem_resp delayed 3 cycles → cache_resp one cycle after IDLE, then pmem_write with address 0x1230, data A…A; wb_empty=1 after pmem_resp.
- Read hit: write 0x4000/B…B, then immediately cache_read 0x4006 → cache_rdata=B…B, cache_resp in 2 cycles, pmem_read never asserted.
- Coalesce: back-to-back writes 0x5000/C…C then 0x5008/D…D → count stays 1; the single drain writes 0x5000 with D…D.
- Full (DEPTH=2): back-to-back writes to 0x1000, 0x2000, 0x3000 → third write forces drain of 0x1000 first; third cache_resp only after that pmem_resp; later drains in order 0x2000, 0x3000.
- Read bypass: buffer holds 0x7000; cache_read 0x6000 issued in IDLE → pmem_read 0x6000 precedes pmem_write 0x7000; cache_rdata equals pmem_rdata.
